// File: rtl/wb_dbg_pkg.sv
// wb_dbg_pkg: shared response sub-type codes, ASCII constants, encoder state type and byte helpers
//   RSP_*     : sub-type codes carried in response word bits [33:32]
//   SPC_*     : special-response codes carried in payload bits [31:29]
//   ASCII_*   : prefix characters and the message terminator
//   nib2hex   : nibble -> lowercase ASCII hex digit
//   rsp_prefix: sub-type/special code -> prefix character
//   has_hex   : sub-types whose payload is printed as eight hex digits
package wb_dbg_pkg;
   localparam int RSP_W = 34;
   localparam logic [1:0] RSP_SUB_DATA    = 2'b00;
   localparam logic [1:0] RSP_SUB_ACK     = 2'b01;
   localparam logic [1:0] RSP_SUB_ADDR    = 2'b10;
   localparam logic [1:0] RSP_SUB_SPECIAL = 2'b11;
   localparam logic [2:0] SPC_RESET  = 3'h0;
   localparam logic [2:0] SPC_BUSERR = 3'h1;
   localparam logic [7:0] ASCII_R  = 8'h52;
   localparam logic [7:0] ASCII_K  = 8'h4B;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_Z  = 8'h5A;
   localparam logic [7:0] ASCII_E  = 8'h45;
   localparam logic [7:0] ASCII_S  = 8'h53;
   localparam logic [7:0] ASCII_NL = 8'h0A;
   typedef enum logic [1:0] {ST_IDLE, ST_PREFIX, ST_HEX, ST_NEWLINE} enc_state_t;
   function automatic logic [7:0] nib2hex(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
   endfunction
   function automatic logic [7:0] rsp_prefix(input logic [1:0] sub, input logic [2:0] code);
      return (sub == RSP_SUB_DATA) ? ASCII_R :
             (sub == RSP_SUB_ACK)  ? ASCII_K :
             (sub == RSP_SUB_ADDR) ? ASCII_A :
             (code == SPC_RESET)   ? ASCII_Z :
             (code == SPC_BUSERR)  ? ASCII_E : ASCII_S;
   endfunction
   function automatic logic has_hex(input logic [1:0] sub);
      return (sub == RSP_SUB_DATA) || (sub == RSP_SUB_ADDR);
   endfunction
endpackage

// File: rtl/rsp_fifo.sv
// rsp_fifo: synchronous FIFO of 2**LGFIFO response words
//   i_clk, i_reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data : write a word; caller must not push when full unless also popping
//   i_pop, o_data  : o_data shows the head word; i_pop discards it (never when empty)
//   o_full, o_empty, o_count : occupancy
module rsp_fifo
   import wb_dbg_pkg::*;
#(
   parameter int LGFIFO = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic [RSP_W-1:0]  i_data,
   input  logic              i_pop,
   output logic [RSP_W-1:0]  o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [LGFIFO:0]   o_count
);
   localparam int DEPTH = 1 << LGFIFO;
   logic [RSP_W-1:0]  r_mem [DEPTH];
   logic [LGFIFO-1:0] r_wr;
   logic [LGFIFO-1:0] r_rd;
   logic [LGFIFO:0]   r_count;
   // Storage carries no reset so it can map onto RAM.
   always_ff @(posedge i_clk)
      if (i_push) r_mem[r_wr] <= i_data;
   always_ff @(posedge i_clk)
      if (i_reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + LGFIFO'(1);
         if (i_pop) r_rd <= r_rd + LGFIFO'(1);
         r_count <= r_count + {LGFIFO'(0), i_push} - {LGFIFO'(0), i_pop};
      end
   assign o_data  = r_mem[r_rd];
   assign o_full  = r_count == (LGFIFO + 1)'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_count = r_count;
endmodule

// File: rtl/wb_rsp_encoder.sv
// wb_rsp_encoder: buffers 34-bit bus-master responses and serializes each as printable ASCII toward a UART
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_rsp_stb, i_rsp_word   : single-cycle response word, no backpressure
//   o_tx_stb, o_tx_data     : registered byte toward UART TX, held while i_tx_busy
//   i_tx_busy               : UART not ready; a byte moves when o_tx_stb && !i_tx_busy
//   o_busy                  : FIFO non-empty or a message in flight
//   o_overflow              : sticky, a response was dropped on a full FIFO
module wb_rsp_encoder
   import wb_dbg_pkg::*;
#(
   parameter int LGFIFO = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rsp_stb,
   input  logic [RSP_W-1:0]  i_rsp_word,
   output logic              o_tx_stb,
   output logic [7:0]        o_tx_data,
   input  logic              i_tx_busy,
   output logic              o_busy,
   output logic              o_overflow
);
   enc_state_t       r_state;
   logic [RSP_W-1:0] r_msg;
   logic [2:0]       r_cnt;
   logic [RSP_W-1:0] w_fifo_data;
   logic [LGFIFO:0]  w_count;
   logic [LGFIFO:0]  w_count_next;
   logic [2:0]       w_cnt_dec;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_xfer;
   logic             w_next_active;
   assign w_pop  = (r_state == ST_IDLE) && !w_empty;
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign w_push = i_rsp_stb && (!w_full || w_pop);
   assign w_xfer = o_tx_stb && !i_tx_busy;
   assign w_cnt_dec = r_cnt - 3'd1;
   // o_busy tracks the post-edge state so it rises with the push and falls with the final newline.
   assign w_count_next  = w_count + {LGFIFO'(0), w_push} - {LGFIFO'(0), w_pop};
   assign w_next_active = (r_state == ST_IDLE) ? w_pop : !((r_state == ST_NEWLINE) && w_xfer);
   rsp_fifo #(.LGFIFO(LGFIFO)) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_data  (i_rsp_word),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   always_ff @(posedge i_clk)
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_msg      <= '0;
         r_cnt      <= '0;
         o_tx_stb   <= 1'b0;
         o_tx_data  <= 8'h00;
         o_busy     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_busy <= (w_count_next != '0) || w_next_active;
         if (i_rsp_stb && w_full && !w_pop) o_overflow <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               o_tx_stb <= 1'b0;
               if (w_pop) begin
                  r_msg   <= w_fifo_data;
                  r_state <= ST_PREFIX;
               end
            end
            // First cycle in PREFIX loads the prefix byte; the transfer advances afterwards.
            ST_PREFIX:
               if (!o_tx_stb) begin
                  o_tx_stb  <= 1'b1;
                  o_tx_data <= rsp_prefix(r_msg[33:32], r_msg[31:29]);
               end else if (w_xfer) begin
                  if (has_hex(r_msg[33:32])) begin
                     r_state   <= ST_HEX;
                     r_cnt     <= 3'd7;
                     o_tx_data <= nib2hex(r_msg[31:28]);
                  end else begin
                     r_state   <= ST_NEWLINE;
                     o_tx_data <= ASCII_NL;
                  end
               end
            ST_HEX:
               if (w_xfer) begin
                  if (r_cnt == 3'd0) begin
                     r_state   <= ST_NEWLINE;
                     o_tx_data <= ASCII_NL;
                  end else begin
                     r_cnt     <= w_cnt_dec;
                     o_tx_data <= nib2hex(r_msg[{w_cnt_dec, 2'b00} +: 4]);
                  end
               end
            ST_NEWLINE:
               if (w_xfer) begin
                  r_state  <= ST_IDLE;
                  o_tx_stb <= 1'b0;
               end
            default: r_state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_wb_rsp_encoder.sv
// tb_wb_rsp_encoder: directed checks of the response-to-ASCII encoder
module tb_wb_rsp_encoder;
   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_rsp_stb;
   logic [33:0] i_rsp_word;
   logic        o_tx_stb;
   logic [7:0]  o_tx_data;
   logic        i_tx_busy;
   logic        o_busy;
   logic        o_overflow;
   int vecs = 0;
   int errs = 0;
   bit bp = 1'b0;
   int bp_cyc = 0;
   string hs = "0123456789abcdef";
   always #5 i_clk = ~i_clk;
   wb_rsp_encoder #(.LGFIFO(4)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_rsp_stb  (i_rsp_stb),
      .i_rsp_word (i_rsp_word),
      .o_tx_stb   (o_tx_stb),
      .o_tx_data  (o_tx_data),
      .i_tx_busy  (i_tx_busy),
      .o_busy     (o_busy),
      .o_overflow (o_overflow)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic [33:0] w);
      i_rsp_stb  = 1'b1;
      i_rsp_word = w;
      @(negedge i_clk);
      i_rsp_stb  = 1'b0;
   endtask
   // Collects n bytes (first byte in the top used byte of v), checking holds under busy.
   task automatic get_msg(input string tag, input logic [127:0] v, input int n, input bit consec);
      int i = 0;
      int idle = 0;
      int gaps = 0;
      logic hold = 1'b0;
      logic [7:0] hd = 8'h00;
      while (i < n && idle < 300) begin
         if (hold) chk({tag, "_hold"}, 32'({o_tx_stb, o_tx_data}), 32'({1'b1, hd}));
         if (bp) begin
            i_tx_busy = ((bp_cyc / 3) % 2) == 1;
            bp_cyc++;
         end
         if (o_tx_stb && !i_tx_busy) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(o_tx_data), 32'(v[8*(n-1-i) +: 8]));
            i++;
            idle = 0;
         end else begin
            idle++;
            if (i > 0) gaps++;
         end
         hold = o_tx_stb && i_tx_busy;
         hd = o_tx_data;
         @(negedge i_clk);
      end
      if (i < n) chk({tag, "_timeout"}, 32'(i), 32'(n));
      if (consec) chk({tag, "_gaps"}, 32'(gaps), 32'd0);
   endtask
   task automatic quiet(input string tag, input int c);
      int s = 0;
      repeat (c) begin
         if (o_tx_stb) s++;
         @(negedge i_clk);
      end
      chk(tag, 32'(s), 32'd0);
   endtask
   function automatic logic [33:0] wk(input int k);
      return (k % 2 == 1) ? {2'b00, 32'hA5A5_0000 | 32'(k)} : {2'b01, 32'(k)};
   endfunction
   function automatic logic [127:0] expv(input int k);
      return (k % 2 == 1) ?
         128'({8'h52, 8'h61, 8'h35, 8'h61, 8'h35, 8'h30, 8'h30, hs[k >> 4], hs[k & 15], 8'h0A}) :
         128'({8'h4B, 8'h0A});
   endfunction
   function automatic int explen(input int k);
      return (k % 2 == 1) ? 10 : 2;
   endfunction
   initial begin
      i_reset = 1'b1;
      i_rsp_stb = 1'b0;
      i_rsp_word = '0;
      i_tx_busy = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("rst_stb", 32'(o_tx_stb), 32'd0);
      chk("rst_data", 32'(o_tx_data), 32'h00);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_ovf", 32'(o_overflow), 32'd0);
      i_reset = 1'b0;
      @(negedge i_clk);
      // data word, latency and consecutive bytes
      push({2'b00, 32'hDEADBEEF});
      chk("t1_lat1", 32'(o_tx_stb), 32'd0);
      chk("t1_busy", 32'(o_busy), 32'd1);
      @(negedge i_clk);
      chk("t1_lat2", 32'(o_tx_stb), 32'd0);
      @(negedge i_clk);
      chk("t1_first", 32'({o_tx_stb, o_tx_data}), 32'({1'b1, 8'h52}));
      get_msg("t1", 128'({8'h52, 8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A}), 10, 1'b1);
      chk("t1_idle", 32'(o_busy), 32'd0);
      // write ack
      push({2'b01, 32'h0});
      get_msg("t2", 128'({8'h4B, 8'h0A}), 2, 1'b1);
      chk("t2_busy", 32'(o_busy), 32'd0);
      @(negedge i_clk);
      chk("t2_stb", 32'(o_tx_stb), 32'd0);
      // address and specials
      push({2'b10, 32'h00000104});
      get_msg("t3_addr", 128'({8'h41, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h30, 8'h34, 8'h0A}), 10, 1'b1);
      push({2'b11, 3'h1, 29'h0});
      get_msg("t3_err", 128'({8'h45, 8'h0A}), 2, 1'b1);
      push({2'b11, 3'h0, 29'h0});
      get_msg("t3_rst", 128'({8'h5A, 8'h0A}), 2, 1'b1);
      push({2'b11, 3'h5, 29'h1ABCDEF});
      get_msg("t3_spc", 128'({8'h53, 8'h0A}), 2, 1'b1);
      // backpressure toggling every 3 cycles
      bp = 1'b1;
      bp_cyc = 0;
      push({2'b00, 32'h01234567});
      get_msg("t4", 128'({8'h52, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h0A}), 10, 1'b0);
      bp = 1'b0;
      i_tx_busy = 1'b0;
      quiet("t4_quiet", 10);
      // overflow: 18 pushes while the UART stalls, 17 survive
      i_tx_busy = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         if (k == 18) chk("t5_ovf_pre", 32'(o_overflow), 32'd0);
         i_rsp_stb = 1'b1;
         i_rsp_word = wk(k);
         @(negedge i_clk);
      end
      i_rsp_stb = 1'b0;
      chk("t5_ovf", 32'(o_overflow), 32'd1);
      chk("t5_busy", 32'(o_busy), 32'd1);
      i_tx_busy = 1'b0;
      for (int k = 1; k <= 17; k++) get_msg($sformatf("t5_m%0d", k), expv(k), explen(k), 1'b0);
      quiet("t5_quiet", 20);
      chk("t5_ovf_sticky", 32'(o_overflow), 32'd1);
      chk("t5_idle", 32'(o_busy), 32'd0);
      // reset mid-message
      push({2'b00, 32'hCAFEF00D});
      get_msg("t6_part", 128'({8'h52, 8'h63, 8'h61}), 3, 1'b1);
      chk("t6_mid", 32'({o_tx_stb, o_tx_data}), 32'({1'b1, 8'h66}));
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("t6_stb", 32'(o_tx_stb), 32'd0);
      chk("t6_data", 32'(o_tx_data), 32'h00);
      chk("t6_busy", 32'(o_busy), 32'd0);
      chk("t6_ovf", 32'(o_overflow), 32'd0);
      i_reset = 1'b0;
      @(negedge i_clk);
      push({2'b01, 32'h0});
      get_msg("t6_ack", 128'({8'h4B, 8'h0A}), 2, 1'b1);
      quiet("t6_quiet", 20);
      // push into a full FIFO on the same edge as a pop
      i_tx_busy = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         i_rsp_stb = 1'b1;
         i_rsp_word = {2'b01, 32'(k)};
         @(negedge i_clk);
      end
      i_rsp_stb = 1'b0;
      chk("t7_ovf_full", 32'(o_overflow), 32'd0);
      i_tx_busy = 1'b0;
      get_msg("t7_first", 128'({8'h4B, 8'h0A}), 2, 1'b1);
      chk("t7_gap", 32'(o_tx_stb), 32'd0);
      push({2'b00, 32'h89ABCDEF});
      chk("t7_ovf", 32'(o_overflow), 32'd0);
      for (int k = 2; k <= 17; k++) get_msg($sformatf("t7_a%0d", k), 128'({8'h4B, 8'h0A}), 2, 1'b0);
      get_msg("t7_data", 128'({8'h52, 8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h0A}), 10, 1'b1);
      quiet("t7_quiet", 20);
      chk("t7_ovf_end", 32'(o_overflow), 32'd0);
      chk("t7_idle", 32'(o_busy), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
